// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types for the common data bus: default widths, functional-unit ids and the
// broadcast record consumed by reservation stations and the register file.
package cdb_arbiter_pkg;

  localparam int unsigned CdbTagW  = 4;
  localparam int unsigned CdbDataW = 32;

  typedef enum logic [1:0] {
    FuAlu0,
    FuAlu1,
    FuMul,
    FuLsu
  } e_functional_unit;

  typedef struct packed {
    logic                valid;
    logic [CdbTagW-1:0]  tag;
    logic [CdbDataW-1:0] data;
  } cdb_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Wrap-around first-set search: grants the lowest requester at or above ptr, else the lowest
// requester below ptr. Purely combinational, output one-hot or zero.
module rr_priority_picker #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_UNITS-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
      if (!found && req[j] && (j >= 32'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    // Wrapped pass covers units below the pointer.
    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
      if (!found && req[j] && (j < 32'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one result per cycle is broadcast, registered,
// with back-pressure, squash, a sticky zero-tag error flag and a saturating broadcast counter.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned TAG_W     = CdbTagW,
  parameter int unsigned DATA_W    = CdbDataW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_UNITS-1:0]             req,
  input  logic [NUM_UNITS-1:0][TAG_W-1:0]  req_tag,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0] req_data,
  output logic [NUM_UNITS-1:0]             gnt,
  input  logic                             hold,
  input  logic                             flush,
  output logic                             cdb_valid,
  output logic [TAG_W-1:0]                 cdb_tag,
  output logic [DATA_W-1:0]                cdb_data,
  output logic                             tag_err,
  output logic [15:0]                      bcast_count
);

  localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_UNITS-1:0] pick_gnt;
  logic                 handshake;
  logic                 bcast;
  logic [PtrW-1:0]      sel_idx;
  logic [TAG_W-1:0]     sel_tag;
  logic [DATA_W-1:0]    sel_data;

  rr_priority_picker #(
    .NUM_UNITS(NUM_UNITS),
    .PTR_W    (PtrW)
  ) u_picker (
    .req(req),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt)
  );

  // rst > flush > hold: any of them masks the grant, so no handshake can occur.
  assign gnt = (rst || flush || hold) ? '0 : pick_gnt;

  always_comb begin
    handshake = |gnt;
    sel_idx   = '0;
    sel_tag   = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (gnt[i]) begin
        sel_idx  = PtrW'(i);
        sel_tag  = req_tag[i];
        sel_data = req_data[i];
      end
    end
    bcast    = handshake && (sel_tag != '0);
    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = (sel_idx == PtrW'(NUM_UNITS - 1)) ? '0 : sel_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      tag_err     <= 1'b0;
      bcast_count <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cdb_valid <= bcast;
      if (bcast) begin
        cdb_tag  <= sel_tag;
        cdb_data <= sel_data;
      end
      // A zero tag has no consumer: the slot is burned and the error latched.
      if (handshake && !bcast) begin
        tag_err <= 1'b1;
      end
      if (bcast && (bcast_count != 16'hFFFF)) begin
        bcast_count <= bcast_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of functional units competing for the common data bus.
REQ-002 SHALL have parameter TAG_W, default 4, width of reservation-station tag; tag 0 means "no producer".
REQ-003 SHALL have parameter DATA_W, default 32, width of broadcast result.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have req  input  NUM_UNITS  per-unit result-ready request.
REQ-007 SHALL have req_tag  input  NUM_UNITS x TAG_W  per-unit producing-station tag.
REQ-008 SHALL have req_data  input  NUM_UNITS x DATA_W  per-unit result value.
REQ-009 SHALL have gnt  output  NUM_UNITS  one-hot or zero grant, combinational.
REQ-010 SHALL have hold  input  1  downstream back-pressure; suppresses new grants.
REQ-011 SHALL have flush  input  1  mispredict/squash; suppresses grants and kills next broadcast.
REQ-012 SHALL have cdb_valid  output  1  registered broadcast strobe.
REQ-013 SHALL have cdb_tag  output  TAG_W  registered broadcast tag.
REQ-014 SHALL have cdb_data  output  DATA_W  registered broadcast value.
REQ-015 SHALL have tag_err  output  1  sticky: a request with tag 0 was granted.
REQ-016 SHALL have bcast_count  output  16  saturating count of broadcasts.

Function
REQ-017 SHALL assert at most one gnt bit per cycle; gnt[i] high only if req[i] high.
REQ-018 SHALL grant the first requesting unit at or after rr_ptr, searching upward and wrapping NUM_UNITS-1 -> 0.
REQ-019 SHALL treat req[i] & gnt[i] as the handshake; a requester holds req, tag and data stable until granted.
REQ-020 SHALL, on handshake from unit k, set rr_ptr to (k+1) mod NUM_UNITS at the next edge; no handshake leaves rr_ptr unchanged.
REQ-021 SHALL, on handshake with nonzero tag, drive cdb_valid=1, cdb_tag, cdb_data of unit k in the next cycle (latency 1).
REQ-022 SHALL drive cdb_valid=0 in any cycle following a cycle with no handshake; cdb_tag/cdb_data then hold their last values.
REQ-023 SHALL, on handshake with tag 0, consume the request, advance rr_ptr, set tag_err, and drive cdb_valid=0 next cycle.
REQ-024 SHALL force gnt=0 while hold is high; rr_ptr unchanged; cdb_valid=0 next cycle.
REQ-025 SHALL force gnt=0 while flush is high, regardless of hold; rr_ptr unchanged; cdb_valid=0 next cycle.
REQ-026 SHALL apply priority rst > flush > hold > arbitration.
REQ-027 SHALL bound wait of a continuously requesting unit to NUM_UNITS-1 handshakes by others, absent hold/flush.
REQ-028 SHALL increment bcast_count in the cycle after each cdb_valid-producing handshake, saturating at 0xFFFF.

Reset
REQ-029 SHALL, on rst high at a posedge, set rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, tag_err=0, bcast_count=0.
REQ-030 SHALL force gnt=0 during any cycle rst is high; a handshake pending in that cycle is lost, and requesters re-request.
REQ-031 SHALL grant unit 0 first after reset if it requests.

Structure
REQ-032 SHALL take TAG_W/DATA_W defaults, e_functional_unit and a cdb_t struct (valid, tag, data) from the shared CPU package; the reservation stations and register file consume cdb_t.
REQ-033 SHALL place the wrap-around first-set search in a combinational sub-module rr_priority_picker (inputs req, ptr; output one-hot gnt).

Verification
REQ-034 SHALL cover: req=4'b1111 held, tags 1..4, data 0xA0..0xA3 -> grants 0,1,2,3,0; cdb_tag 1,2,3,4,1 each one cycle later.
REQ-035 SHALL cover: rr_ptr=3, req=4'b0011 -> gnt=4'b0001 (wrap), rr_ptr becomes 1.
REQ-036 SHALL cover: req[2]=1 tag 5 data 0xDEAD, hold=1 for 3 cycles -> gnt=0, cdb_valid=0; release -> cdb tag 5 data 0xDEAD next cycle.
REQ-037 SHALL cover: flush and hold both high with req=4'b0100 -> gnt=0, rr_ptr unchanged, cdb_valid=0 next cycle.
REQ-038 SHALL cover: req[1]=1 with tag 0 -> gnt[1]=1, cdb_valid=0 next cycle, tag_err=1 and sticky until rst.
REQ-039 SHALL cover: rst asserted mid-stream with req=4'b1010 -> all outputs zero next cycle, first post-reset grant to unit 1.
